// File: rtl/dtc_sched_pkg.sv
// Shared types and default sizing for the decision-tree classifier scheduler.
// Latency: none (types only). Backpressure: n/a.
package dtc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int FEAT_W_DEF  = 7;
  localparam int CNT_W_DEF   = 16;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/dtc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Latency: zero cycles. Backpressure: none, pure function of req and ptr.
module dtc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    // ptr is always < NUM_REQ, so one subtraction is enough to wrap.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_idx         = ID_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtc_rr_scheduler.sv
// Round-robin sharing of one external combinational classifier among NUM_REQ requesters.
// Latency: accept -> rsp_valid 2 cycles, 3 cycles min per transaction. Backpressure: holds RESP until rsp_ready.
module dtc_rr_scheduler
  import dtc_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int FEAT_W  = FEAT_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FEAT_W-1:0] req_feat,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_class,
  output logic [FEAT_W-1:0]         cls_inp,
  input  logic                      cls_outp,
  output logic [CNT_W-1:0]          done_cnt
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [FEAT_W-1:0]   cls_inp_q, cls_inp_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_class_q, rsp_class_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [FEAT_W-1:0]   feat_sel;

  dtc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req          (req_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) feat_sel = req_feat[i*FEAT_W +: FEAT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cls_inp_d   = cls_inp_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_class_d = rsp_class_q;
    done_cnt_d  = done_cnt_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          // Ready is gated by rst so a requester never sees an accept that reset discards.
          req_ready = rst ? '0 : pick_onehot;
          cls_inp_d = feat_sel;
          rsp_id_d  = pick_idx;
          rr_ptr_d  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          state_d   = EVAL;
        end
      end
      EVAL: begin
        rsp_class_d = cls_outp;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cls_inp_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_class_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cls_inp_q   <= cls_inp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_class_q <= rsp_class_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign cls_inp   = cls_inp_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_class = rsp_class_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_dtc_rr_scheduler.sv
// Directed bench for dtc_rr_scheduler with a one-bit classifier stub (~cls_inp[0]).
module tb_dtc_rr_scheduler;

  localparam int NR = 4;
  localparam int FW = 7;
  localparam int IW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*FW-1:0] req_feat;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic            rsp_class;
  logic [FW-1:0]   cls_inp;
  logic            cls_outp;
  logic [CW-1:0]   done_cnt;

  int n_chk = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  assign cls_outp = ~cls_inp[0];

  dtc_rr_scheduler #(
    .NUM_REQ (NR),
    .FEAT_W  (FW),
    .ID_W    (IW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_feat  (req_feat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_class (rsp_class),
    .cls_inp   (cls_inp),
    .cls_outp  (cls_outp),
    .done_cnt  (done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_feats(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                           input logic [FW-1:0] f2, input logic [FW-1:0] f3);
    req_feat = {f3, f2, f1, f0};
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    set_feats(7'h11, 7'h22, 7'h33, 7'h44);
    tick();
    tick();
    // Reset state, with every request valid to show req_ready is gated.
    #1;
    chk("rst_rdy",   32'(req_ready), 32'h0);
    chk("rst_vld",   32'(rsp_valid), 32'h0);
    chk("rst_id",    32'(rsp_id),    32'h0);
    chk("rst_cls",   32'(rsp_class), 32'h0);
    chk("rst_inp",   32'(cls_inp),   32'h0);
    chk("rst_cnt",   32'(done_cnt),  32'h0);
    tick();

    // Single request from requester 2.
    rst       = 1'b0;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    set_feats(7'h00, 7'h00, 7'h2A, 7'h00);
    #1;
    chk("one_rdy", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    set_feats(7'h00, 7'h00, 7'h55, 7'h00);
    #1;
    chk("one_inp",   32'(cls_inp),   32'h2A);
    chk("one_rdy2",  32'(req_ready), 32'h0);
    chk("one_vld0",  32'(rsp_valid), 32'h0);
    tick();
    #1;
    chk("one_vld",   32'(rsp_valid), 32'h1);
    chk("one_id",    32'(rsp_id),    32'h2);
    chk("one_cls",   32'(rsp_class), 32'h1);
    tick();
    #1;
    chk("one_vld_off", 32'(rsp_valid), 32'h0);
    chk("one_cnt",     32'(done_cnt),  32'h1);
    chk("one_hold_inp", 32'(cls_inp),  32'h2A);

    // Reset pulse so the pointer starts from 0 for the round-robin pass.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    set_feats(7'h01, 7'h02, 7'h03, 7'h04);
    for (int c = 0; c < 15; c++) begin
      automatic int t = c / 3;
      automatic int g = t % 4;
      automatic logic [31:0] exp_cls = (g % 2 == 1) ? 32'h1 : 32'h0;
      #1;
      if (c % 3 == 0) chk("rr_rdy_pulse", 32'(req_ready), 32'(1) << g);
      else            chk("rr_rdy_zero",  32'(req_ready), 32'h0);
      if (c % 3 == 2) begin
        chk("rr_vld", 32'(rsp_valid), 32'h1);
        chk("rr_id",  32'(rsp_id),    32'(g));
        chk("rr_cls", 32'(rsp_class), exp_cls);
      end
      tick();
    end
    #1;
    chk("rr_cnt", 32'(done_cnt), 32'h5);

    // Backpressure: requester 1 (pointer now 1), response held for 10 cycles.
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("bp_eval_rdy", 32'(req_ready), 32'h0);
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_vld", 32'(rsp_valid), 32'h1);
      chk("bp_id",  32'(rsp_id),    32'h1);
      chk("bp_cls", 32'(rsp_class), 32'h1);
      chk("bp_rdy", 32'(req_ready), 32'h0);
      chk("bp_cnt", 32'(done_cnt),  32'h5);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_cnt_once", 32'(done_cnt),  32'h6);
    chk("bp_vld_off",  32'(rsp_valid), 32'h0);
    chk("bp_next",     32'(req_ready), 32'h4);
    tick();
    tick();
    tick();

    // Pointer wrap and skip: grant 3, then 0110 gives 1 then 2.
    #1;
    chk("wrap_g3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0110;
    tick();
    tick();
    #1;
    chk("skip_g1", 32'(req_ready), 32'h2);
    tick();
    tick();
    tick();
    #1;
    chk("skip_g2", 32'(req_ready), 32'h4);
    tick();

    // Reset while in EVAL (pointer is 3 at this point).
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_eval_rdy", 32'(req_ready), 32'h0);
    tick();
    #1;
    chk("mid_vld", 32'(rsp_valid), 32'h0);
    chk("mid_rdy", 32'(req_ready), 32'h0);
    chk("mid_cnt", 32'(done_cnt),  32'h0);
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("mid_first", 32'(req_ready), 32'h1);
    tick();
    tick();
    #1;
    chk("mid_vld2", 32'(rsp_valid), 32'h1);
    chk("mid_id",   32'(rsp_id),    32'h0);
    tick();
    #1;
    chk("mid_cnt1", 32'(done_cnt), 32'h1);

    // Counter wrap: 15 more handshakes bring the 4-bit count back to 0.
    exp_cnt   = 4'd1;
    req_valid = 4'b1111;
    for (int n = 0; n < 15; n++) begin
      tick();
      tick();
      tick();
      exp_cnt = exp_cnt + 4'd1;
      #1;
      chk("wrap_cnt", 32'(done_cnt), 32'(exp_cnt));
    end
    chk("wrap_zero", 32'(done_cnt), 32'h0);
    chk("wrap_vld",  32'(rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dtc_rr_scheduler.md
Name: dtc_rr_scheduler

Overview:
- Shares one combinational decision-tree classifier among NUM_REQ requesters.
- Each requester presents a FEAT_W-bit feature vector with a valid/ready handshake.
- The block arbitrates round-robin, registers the winning vector onto the classifier input, captures the class bit, and returns it tagged with the requester ID over a valid/ready response port.
- It sits between the feature-extraction front ends and any generated dtc_* tree; the classifier is external, so any tree with matching widths can be bound.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FEAT_W, 7, feature vector width; must match the classifier input.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_feat  in  NUM_REQ*FEAT_W  feature vectors; requester i occupies bits [i*FEAT_W +: FEAT_W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  ID_W  index of the requester the result belongs to
- rsp_class  out  1  classifier result
- cls_inp  out  FEAT_W  registered drive to the shared classifier input
- cls_outp  in  1  classifier output (combinational function of cls_inp)
- done_cnt  out  CNT_W  count of completed response handshakes

Behaviour:
- Reset (rst=1 at a clk edge) forces all of the following; req_ready is also 0 in any cycle where rst=1:
  - state=IDLE, rr_ptr=0
  - cls_inp=0, rsp_valid=0, rsp_id=0, rsp_class=0, done_cnt=0
- Reset mid-transaction abandons the transaction. No response is produced, and the requester is not re-served unless it still holds valid.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid is high, the grant g = first set bit searching from index rr_ptr upward, wrapping mod NUM_REQ.
  - req_ready[g]=1 (combinational, this cycle only). All other req_ready bits are 0.
  - At the edge: cls_inp<=req_feat[g], rsp_id<=g, rr_ptr<=(g+1) mod NUM_REQ, state<=EVAL.
  - If no req_valid is high, stay in IDLE; rr_ptr is unchanged.
- EVAL:
  - req_ready=0. cls_inp is held stable for one full cycle.
  - At the edge: rsp_class<=cls_outp, rsp_valid<=1, state<=RESP.
- RESP:
  - req_ready=0. rsp_valid=1; rsp_id and rsp_class are held stable until the handshake.
  - On rsp_valid&rsp_ready at the edge: rsp_valid<=0, done_cnt<=done_cnt+1 (wraps from all-ones to 0), state<=IDLE.
  - Without rsp_ready, stay in RESP indefinitely (backpressure). New requests wait.
- Latency and throughput:
  - Request acceptance to rsp_valid: 2 cycles.
  - Minimum 3 cycles per transaction (IDLE, EVAL, RESP, with rsp_ready held high).
- Handshake rules:
  - Requesters must hold req_valid and req_feat until req_ready.
  - The block samples req_feat only in the accept cycle. Later changes to the source vector do not affect the result.
  - req_valid dropping before acceptance is legal and simply removes the request from arbitration.
- Fairness: with all requesters continuously valid, the grants cycle 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ grants.
- cls_inp retains its last value in IDLE; it is not cleared between transactions.

Decomposition:
- Package dtc_sched_pkg holds:
  - the state enum (IDLE, EVAL, RESP) with a 2-bit encoding
  - default constants NUM_REQ, FEAT_W, CNT_W
  - a clog2-based ID_W helper constant
- One natural sub-module: dtc_rr_pick. It is a purely combinational round-robin picker with inputs req[NUM_REQ] and ptr[ID_W], and outputs grant_onehot[NUM_REQ], grant_idx[ID_W] and any.
- The top level holds the FSM, the registers and the counter.

Test Plan:
- Bench stub: cls_outp = ~cls_inp[0].
- Single request: req_valid=4'b0100, feat2=7'h2A, rsp_ready=1 -> req_ready=4'b0100 for 1 cycle; cls_inp=7'h2A 1 cycle later; rsp_valid 2 cycles after accept with rsp_id=2, rsp_class=1; done_cnt=1.
- Round-robin: all four valid continuously, feats 7'h01,7'h02,7'h03,7'h04, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; rsp_class sequence 0,1,0,1,0; exactly one req_ready pulse every 3 cycles.
- Backpressure: one transaction with rsp_ready=0 for 10 cycles, then 1 -> rsp_valid held with stable id/class; req_ready stays 0 throughout; done_cnt increments exactly once; next grant follows.
- Pointer wrap/skip: after a grant to requester 3, with req_valid=4'b0110 -> next grant is 1, then 2.
- Reset mid-operation: assert rst in EVAL -> next cycle rsp_valid=0, req_ready=0, done_cnt=0, rr_ptr=0; with req_valid=4'b1001 after release -> requester 0 is granted first.
- Counter wrap: run 65536 handshakes (or force CNT_W=4 and run 16) -> done_cnt returns to 0 with no other effect.
